// File: rtl/wrr_vc_scheduler_pkg.sv
// ============================================================================
// Module      : wrr_pkg
// Description : Shared sizes, reset weight and FSM state codes for the
//               weighted round-robin VC scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wrr_pkg;

  localparam int NUM_VC   = 4;
  localparam int VC_W     = 2;
  localparam int WEIGHT_W = 3;

  localparam logic [WEIGHT_W-1:0] DEF_WEIGHT = 3'd1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // One-hot decode of a VC index
  function automatic logic [NUM_VC-1:0] vc_onehot(input logic [VC_W-1:0] vc);
    return {{(NUM_VC-1){1'b0}}, 1'b1} << vc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wrr_vc_scheduler_if.sv
// ============================================================================
// Module      : wrr_vc_scheduler_if
// Description : Request, weight-config and grant handshake bundle of the
//               WRR VC scheduler. With WRR_STATS_EN defined the statistics
//               select/readback pair is carried as well.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wrr_vc_scheduler_if;
  import wrr_pkg::*;

  logic [NUM_VC-1:0]   req;
  logic                cfg_we;
  logic [VC_W-1:0]     cfg_vc;
  logic [WEIGHT_W-1:0] cfg_weight;
  logic                gnt_ready;
  logic                gnt_valid;
  logic [VC_W-1:0]     gnt_vc;
  logic [NUM_VC-1:0]   gnt_onehot;
  logic [WEIGHT_W-1:0] credit_out;
`ifdef WRR_STATS_EN
  logic [VC_W-1:0]     stat_sel;
  logic [7:0]          stat_cnt;
`endif

  // Requester / configuration side
  modport master (
    output req, cfg_we, cfg_vc, cfg_weight, gnt_ready,
`ifdef WRR_STATS_EN
    output stat_sel,
    input  stat_cnt,
`endif
    input  gnt_valid, gnt_vc, gnt_onehot, credit_out
  );

  // Scheduler side
  modport slave (
    input  req, cfg_we, cfg_vc, cfg_weight, gnt_ready,
`ifdef WRR_STATS_EN
    input  stat_sel,
    output stat_cnt,
`endif
    output gnt_valid, gnt_vc, gnt_onehot, credit_out
  );

endinterface

`default_nettype wire

// File: rtl/wrr_vc_scheduler_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating priority encoder. Returns the first
//               set mask bit at or after ptr, wrapping modulo NUM_VC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import wrr_pkg::*;
(
  input  logic [NUM_VC-1:0] mask,
  input  logic [VC_W-1:0]   ptr,
  output logic              found,
  output logic [VC_W-1:0]   idx
);

  // Candidate VC at each priority offset from the pointer
  logic [VC_W-1:0] w_cand [NUM_VC];

  genvar k;
  generate
    for (k = 0; k < NUM_VC; k++) begin : g_cand
      assign w_cand[k] = ptr + VC_W'(k);
    end
  endgenerate

  // Scan from lowest priority up so the nearest-to-pointer hit is kept last
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = NUM_VC - 1; j >= 0; j--) begin
      if (mask[w_cand[j]]) begin
        found = 1'b1;
        idx   = w_cand[j];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wrr_vc_scheduler.sv
// ============================================================================
// Module      : wrr_vc_scheduler
// Description : Weighted round-robin scheduler for NUM_VC virtual channels.
//               A winning VC gets its table weight as burst credits and is
//               granted until credits run out or its request drops, then the
//               pointer rotates past it. Optional per-VC handshake counters
//               are built when WRR_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrr_vc_scheduler
  import wrr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  wrr_vc_scheduler_if.slave  bus
);

  state_t              r_state;
  logic [VC_W-1:0]     r_ptr;
  logic [WEIGHT_W-1:0] r_weight [NUM_VC];
  logic [WEIGHT_W-1:0] r_credit;
  logic                r_gnt_valid;
  logic [VC_W-1:0]     r_gnt_vc;
  logic [NUM_VC-1:0]   r_gnt_onehot;

  logic [NUM_VC-1:0]   w_elig;
  logic                w_found;
  logic [VC_W-1:0]     w_win;
  logic                w_hs;
  logic                w_more;

  // A VC competes only when it requests and is not disabled by a zero weight
  genvar i;
  generate
    for (i = 0; i < NUM_VC; i++) begin : g_elig
      assign w_elig[i] = bus.req[i] & (r_weight[i] != '0);
    end
  endgenerate

  rr_pick u_pick (
    .mask  (w_elig),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_win)
  );

  assign w_hs   = r_gnt_valid & bus.gnt_ready;
  // Burst continues only while credits remain beyond this grant and the VC still requests
  assign w_more = (r_credit > WEIGHT_W'(1)) & bus.req[r_gnt_vc];

  // Weight table: writes land at the edge, so a same-cycle load sees the old value
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) r_weight[v] <= DEF_WEIGHT;
    end else if (bus.cfg_we) begin
      r_weight[bus.cfg_vc] <= bus.cfg_weight;
    end
  end

  // Grant FSM with registered outputs and burst credit counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_credit     <= '0;
      r_gnt_valid  <= 1'b0;
      r_gnt_vc     <= '0;
      r_gnt_onehot <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state      <= ST_SERVE;
            r_gnt_valid  <= 1'b1;
            r_gnt_vc     <= w_win;
            r_gnt_onehot <= vc_onehot(w_win);
            r_credit     <= r_weight[w_win];
          end
        end
        ST_SERVE: begin
          if (w_hs) begin
            if (w_more) begin
              r_credit <= r_credit - WEIGHT_W'(1);
            end else begin
              r_state      <= ST_IDLE;
              r_gnt_valid  <= 1'b0;
              r_gnt_onehot <= '0;
              r_credit     <= '0;
              r_ptr        <= r_gnt_vc + VC_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.gnt_vc     = r_gnt_vc;
  assign bus.gnt_onehot = r_gnt_onehot;
  assign bus.credit_out = r_credit;

`ifdef WRR_STATS_EN
  logic [7:0] r_stat [NUM_VC];
  logic [7:0] r_stat_cnt;

  // Per-VC handshake counters with registered readback of the selected one
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) r_stat[v] <= '0;
      r_stat_cnt <= '0;
    end else begin
      r_stat_cnt <= r_stat[bus.stat_sel];
      if (w_hs) r_stat[r_gnt_vc] <= r_stat[r_gnt_vc] + 8'd1;
    end
  end

  assign bus.stat_cnt = r_stat_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wrr_vc_scheduler.sv
// ============================================================================
// Module      : tb_wrr_vc_scheduler
// Description : Self-checking bench for wrr_vc_scheduler. A cycle model built
//               from the scheduling rules is compared against the DUT on every
//               cycle; hand-computed grant sequences pin the model. Statistics
//               checks are included when WRR_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wrr_vc_scheduler;
  import wrr_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wrr_vc_scheduler_if bus ();

  wrr_vc_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_w [NUM_VC] = '{1, 1, 1, 1};
  bit m_valid = 1'b0;
  int m_vc    = 0;
  int m_cred  = 0;
  int m_ptr   = 0;
  int hs_log [$];
  bit chk_en  = 1'b0;
`ifdef WRR_STATS_EN
  int m_cnt [NUM_VC] = '{0, 0, 0, 0};
  int m_stat = 0;
`endif

  // Advance the model on each rising edge from the same sampled inputs
  always @(posedge clk) begin : model
    bit hs;
    if (reset === 1'b0) begin
      m_valid = 1'b0; m_vc = 0; m_cred = 0; m_ptr = 0;
      for (int v = 0; v < NUM_VC; v++) m_w[v] = 1;
`ifdef WRR_STATS_EN
      for (int v = 0; v < NUM_VC; v++) m_cnt[v] = 0;
      m_stat = 0;
`endif
    end else begin
      hs = m_valid && (bus.gnt_ready === 1'b1);
`ifdef WRR_STATS_EN
      m_stat = m_cnt[bus.stat_sel];
      if (hs) m_cnt[m_vc] = (m_cnt[m_vc] + 1) % 256;
`endif
      if (hs) hs_log.push_back(m_vc);
      if (!m_valid) begin
        for (int k = 0; k < NUM_VC; k++) begin
          if (bus.req[(m_ptr + k) % NUM_VC] && m_w[(m_ptr + k) % NUM_VC] != 0) begin
            m_valid = 1'b1;
            m_vc    = (m_ptr + k) % NUM_VC;
            m_cred  = m_w[m_vc];
            break;
          end
        end
      end else if (hs) begin
        if (m_cred > 1 && bus.req[m_vc]) begin
          m_cred = m_cred - 1;
        end else begin
          m_ptr   = (m_vc + 1) % NUM_VC;
          m_cred  = 0;
          m_valid = 1'b0;
        end
      end
      if (bus.cfg_we) m_w[bus.cfg_vc] = int'(bus.cfg_weight);
    end
  end

  // Compare DUT outputs with the model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt_valid", 32'(bus.gnt_valid), 32'(m_valid));
      check("gnt_onehot", 32'(bus.gnt_onehot), m_valid ? (32'd1 << m_vc) : 32'd0);
      check("credit_out", 32'(bus.credit_out), 32'(m_cred));
      if (m_valid) check("gnt_vc", 32'(bus.gnt_vc), 32'(m_vc));
`ifdef WRR_STATS_EN
      check("stat_cnt", 32'(bus.stat_cnt), 32'(m_stat));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
`ifdef WRR_STATS_EN
      bus.stat_sel = 2'($urandom_range(0, 3));
`endif
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.req        = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_vc     = '0;
    bus.cfg_weight = '0;
    bus.gnt_ready  = 1'b1;
`ifdef WRR_STATS_EN
    bus.stat_sel   = '0;
`endif
    cycles(2);
    reset = 1'b1;
    hs_log.delete();
    chk_en = 1'b1;
  endtask

  task automatic write_w(input int vc, input int w);
    bus.cfg_we     = 1'b1;
    bus.cfg_vc     = 2'(vc);
    bus.cfg_weight = 3'(w);
    cycles(1);
    bus.cfg_we     = 1'b0;
  endtask

  task automatic check_log(input string name, input int want [$]);
    check({name, "_len"}, 32'(hs_log.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      if (i < hs_log.size()) check(name, 32'(hs_log[i]), 32'(want[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1;
    do_reset();
    check("rst_valid",  32'(bus.gnt_valid),  32'd0);
    check("rst_vc",     32'(bus.gnt_vc),     32'd0);
    check("rst_onehot", 32'(bus.gnt_onehot), 32'd0);
    check("rst_credit", 32'(bus.credit_out), 32'd0);
    cycles(3);

    // 1: default weights, one grant per VC with a bubble in between
    bus.req = 4'hF;
    cycles(10);
    check_log("seq_default", '{0, 1, 2, 3, 0});

    // 2: weights {3,1,2,0}; vc3 never served
    do_reset();
    write_w(0, 3); write_w(1, 1); write_w(2, 2); write_w(3, 0);
    bus.req = 4'hF;
    cycles(13);
    check_log("seq_weighted", '{0, 0, 0, 1, 2, 2, 0, 0, 0});

    // 3: stall mid-burst; grant held even while the request drops
    do_reset();
    write_w(0, 3);
    bus.req = 4'hF;
    cycles(2);
    bus.gnt_ready = 1'b0;
    bus.req       = 4'hE;
    for (int c = 0; c < 5; c++) begin
      cycles(1);
      check("hold_valid",  32'(bus.gnt_valid),  32'd1);
      check("hold_vc",     32'(bus.gnt_vc),     32'd0);
      check("hold_credit", 32'(bus.credit_out), 32'd2);
    end
    bus.req       = 4'hF;
    bus.gnt_ready = 1'b1;
    cycles(2);
    check_log("seq_stall", '{0, 0, 0});

    // 4: request drop on the second handshake ends the burst early
    do_reset();
    write_w(1, 4);
    bus.req = 4'hF;
    cycles(4);
    bus.req = 4'hD;
    cycles(3);
    check_log("seq_reqdrop", '{0, 1, 1, 2});

    // 5: reset during a burst restores weights and pointer
    do_reset();
    write_w(0, 3);
    bus.req = 4'hF;
    cycles(2);
    check("pre_rst_credit", 32'(bus.credit_out), 32'd2);
    reset = 1'b0;
    cycles(1);
    check("mid_rst_valid",  32'(bus.gnt_valid),  32'd0);
    check("mid_rst_credit", 32'(bus.credit_out), 32'd0);
    reset = 1'b1;
    cycles(1);
    check("post_rst_valid",  32'(bus.gnt_valid),  32'd1);
    check("post_rst_vc",     32'(bus.gnt_vc),     32'd0);
    check("post_rst_credit", 32'(bus.credit_out), 32'd1);

    // 6: weight write during a burst applies from the next load
    do_reset();
    write_w(0, 2);
    bus.req = 4'hF;
    cycles(1);
    bus.cfg_we     = 1'b1;
    bus.cfg_vc     = 2'd0;
    bus.cfg_weight = 3'd5;
    cycles(1);
    bus.cfg_we     = 1'b0;
    cycles(13);
    check_log("seq_cfgwrite", '{0, 0, 1, 2, 3, 0, 0, 0, 0, 0});

    bus.req = '0;
    cycles(3);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
